// File: rtl/axa_pkg.sv
// Shared definitions for the 2x2 matrix-multiplier host sequencer:
// FSM state encoding, operand/result slot indices and transfer counts.
package axa_pkg;

    typedef enum logic [2:0] {
        LOAD,
        START,
        WAIT_ACK,
        WAIT_RESULT,
        ACK,
        DRAIN
    } axa_state_t;

    localparam int OPERAND_COUNT = 8;
    localparam int RESULT_COUNT  = 4;

    // Operand slots, in the order words arrive on the input stream
    localparam logic [2:0] IDX_A11 = 3'd0;
    localparam logic [2:0] IDX_A12 = 3'd1;
    localparam logic [2:0] IDX_A21 = 3'd2;
    localparam logic [2:0] IDX_A22 = 3'd3;
    localparam logic [2:0] IDX_B11 = 3'd4;
    localparam logic [2:0] IDX_B12 = 3'd5;
    localparam logic [2:0] IDX_B21 = 3'd6;
    localparam logic [2:0] IDX_B22 = 3'd7;

    // Result slots, in the order words leave on the output stream
    localparam logic [1:0] IDX_C11 = 2'd0;
    localparam logic [1:0] IDX_C12 = 2'd1;
    localparam logic [1:0] IDX_C21 = 2'd2;
    localparam logic [1:0] IDX_C22 = 2'd3;

endpackage

// File: rtl/axa_timeout_watchdog.sv
// Cycle watchdog for the multiplier handshake. The count is cleared while
// clear is high and advances while enable is high; expired rises in the
// cycle whose closing edge would bring the count to TIMEOUT_CYCLES, so the
// owner reacts exactly TIMEOUT_CYCLES edges after the clear.
module axa_timeout_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic input_Clk,
    input  logic input_Reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] count_q;

    assign expired = enable && (count_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Cycle counter; holds once expired so it can never wrap
    always_ff @(posedge input_Clk or negedge input_Reset) begin
        if (!input_Reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && !expired) begin
            count_q <= count_q + 1'b1;
        end
    end

endmodule

// File: rtl/axa_host_sequencer.sv
// Host-side sequencer for the 2x2 floating-point matrix multiplier.
// Collects eight operand words from a valid/ready stream, runs the
// Start/Stable/AB_Ack and Done/C_Ack handshakes, then streams C11..C22 out.
// Optional feature: define AXA_TIMEOUT_EN to add a handshake watchdog that
// aborts to LOAD and raises the sticky err_Timeout flag.
module axa_host_sequencer
    import axa_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  input_Clk,
    input  logic                  input_Reset,
    input  logic [DATA_WIDTH-1:0] in_Word,
    input  logic                  in_Valid,
    output logic                  in_Ready,
    output logic [DATA_WIDTH-1:0] out_Word,
    output logic                  out_Valid,
    input  logic                  out_Ready,
    output logic [DATA_WIDTH-1:0] mult_A11,
    output logic [DATA_WIDTH-1:0] mult_A12,
    output logic [DATA_WIDTH-1:0] mult_A21,
    output logic [DATA_WIDTH-1:0] mult_A22,
    output logic [DATA_WIDTH-1:0] mult_B11,
    output logic [DATA_WIDTH-1:0] mult_B12,
    output logic [DATA_WIDTH-1:0] mult_B21,
    output logic [DATA_WIDTH-1:0] mult_B22,
    output logic                  mult_Start,
    output logic                  mult_Stable,
    input  logic                  mult_AB_Ack,
    input  logic                  mult_Done,
    input  logic [DATA_WIDTH-1:0] mult_C11,
    input  logic [DATA_WIDTH-1:0] mult_C12,
    input  logic [DATA_WIDTH-1:0] mult_C21,
    input  logic [DATA_WIDTH-1:0] mult_C22,
    output logic                  mult_C_Ack,
    output logic                  busy,
    output logic                  err_Timeout
);

    axa_state_t            state_q;
    logic [2:0]            op_idx_q;
    logic [1:0]            res_idx_q;
    logic [DATA_WIDTH-1:0] op_q  [OPERAND_COUNT];
    logic [DATA_WIDTH-1:0] res_q [RESULT_COUNT];
    logic                  wd_expired;
    logic                  in_accept;
    logic                  capture;

    // in_Ready is only ever high in LOAD, so an accept always belongs to LOAD
    assign in_accept = (state_q == LOAD) && in_Valid && in_Ready;
    assign capture   = (state_q == WAIT_RESULT) && mult_Done && !wd_expired;

    assign mult_A11 = op_q[IDX_A11];
    assign mult_A12 = op_q[IDX_A12];
    assign mult_A21 = op_q[IDX_A21];
    assign mult_A22 = op_q[IDX_A22];
    assign mult_B11 = op_q[IDX_B11];
    assign mult_B12 = op_q[IDX_B12];
    assign mult_B21 = op_q[IDX_B21];
    assign mult_B22 = op_q[IDX_B22];

`ifdef AXA_TIMEOUT_EN
    logic wd_clear;
    logic wd_enable;

    // START is the single cycle before WAIT_ACK, so clearing there makes
    // the count start from zero on WAIT_ACK entry
    assign wd_clear  = (state_q == START);
    assign wd_enable = (state_q == WAIT_ACK) || (state_q == WAIT_RESULT) ||
                       (state_q == ACK);

    axa_timeout_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .input_Clk  (input_Clk),
        .input_Reset(input_Reset),
        .clear      (wd_clear),
        .enable     (wd_enable),
        .expired    (wd_expired)
    );

    // Sticky timeout flag; only reset clears it
    always_ff @(posedge input_Clk or negedge input_Reset) begin
        if (!input_Reset) begin
            err_Timeout <= 1'b0;
        end else if (wd_expired) begin
            err_Timeout <= 1'b1;
        end
    end
`else
    assign wd_expired  = 1'b0;
    assign err_Timeout = 1'b0;
`endif

    // Operand capture: slot chosen by the load index, frozen outside LOAD
    always_ff @(posedge input_Clk or negedge input_Reset) begin
        if (!input_Reset) begin
            for (int i = 0; i < OPERAND_COUNT; i++) begin
                op_q[i] <= '0;
            end
        end else if (in_accept) begin
            op_q[op_idx_q] <= in_Word;
        end
    end

    // Result capture on the first mult_Done seen in WAIT_RESULT
    always_ff @(posedge input_Clk or negedge input_Reset) begin
        if (!input_Reset) begin
            for (int i = 0; i < RESULT_COUNT; i++) begin
                res_q[i] <= '0;
            end
        end else if (capture) begin
            res_q[IDX_C11] <= mult_C11;
            res_q[IDX_C12] <= mult_C12;
            res_q[IDX_C21] <= mult_C21;
            res_q[IDX_C22] <= mult_C22;
        end
    end

    // Sequencer FSM with all handshake and stream outputs registered
    always_ff @(posedge input_Clk or negedge input_Reset) begin
        if (!input_Reset) begin
            state_q     <= LOAD;
            op_idx_q    <= '0;
            res_idx_q   <= '0;
            in_Ready    <= 1'b0;
            out_Valid   <= 1'b0;
            out_Word    <= '0;
            mult_Start  <= 1'b0;
            mult_Stable <= 1'b0;
            mult_C_Ack  <= 1'b0;
            busy        <= 1'b0;
        end else if (wd_expired) begin
            // Abandon the transaction; nothing is emitted for it
            state_q     <= LOAD;
            mult_Start  <= 1'b0;
            mult_Stable <= 1'b0;
            mult_C_Ack  <= 1'b0;
            busy        <= 1'b0;
            in_Ready    <= 1'b1;
        end else begin
            case (state_q)
                LOAD: begin
                    in_Ready <= 1'b1;
                    if (in_Valid && in_Ready) begin
                        if (op_idx_q == IDX_B22) begin
                            op_idx_q <= '0;
                            in_Ready <= 1'b0;
                            busy     <= 1'b1;
                            state_q  <= START;
                        end else begin
                            op_idx_q <= op_idx_q + 3'd1;
                        end
                    end
                end
                START: begin
                    mult_Start  <= 1'b1;
                    mult_Stable <= 1'b1;
                    state_q     <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (mult_AB_Ack) begin
                        mult_Start <= 1'b0;
                        state_q    <= WAIT_RESULT;
                    end
                end
                WAIT_RESULT: begin
                    if (mult_Done) begin
                        mult_Stable <= 1'b0;
                        mult_C_Ack  <= 1'b1;
                        state_q     <= ACK;
                    end
                end
                ACK: begin
                    // Present C11 together with the C_Ack release so the
                    // first output appears on DRAIN entry
                    if (!mult_Done) begin
                        mult_C_Ack <= 1'b0;
                        res_idx_q  <= IDX_C11;
                        out_Valid  <= 1'b1;
                        out_Word   <= res_q[IDX_C11];
                        state_q    <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (out_Ready) begin
                        if (res_idx_q == IDX_C22) begin
                            out_Valid <= 1'b0;
                            res_idx_q <= '0;
                            busy      <= 1'b0;
                            in_Ready  <= 1'b1;
                            state_q   <= LOAD;
                        end else begin
                            res_idx_q <= res_idx_q + 2'd1;
                            out_Word  <= res_q[res_idx_q + 2'd1];
                        end
                    end
                end
                default: begin
                    state_q <= LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axa_host_sequencer.sv
// Self-checking bench for axa_host_sequencer: table-driven directed
// transactions, reset/timeout corner cases and randomized transactions
// against a behavioural multiplier model with an output scoreboard.
module tb_axa_host_sequencer;

    logic        clk;
    logic        rst_n;
    logic [31:0] in_Word;
    logic        in_Valid;
    logic        in_Ready;
    logic [31:0] out_Word;
    logic        out_Valid;
    logic        out_Ready;
    logic [31:0] mult_A11, mult_A12, mult_A21, mult_A22;
    logic [31:0] mult_B11, mult_B12, mult_B21, mult_B22;
    logic        mult_Start, mult_Stable, mult_AB_Ack, mult_Done, mult_C_Ack;
    logic [31:0] mult_C11, mult_C12, mult_C21, mult_C22;
    logic        busy, err_Timeout;

    axa_host_sequencer #(
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .input_Clk  (clk),
        .input_Reset(rst_n),
        .in_Word    (in_Word),
        .in_Valid   (in_Valid),
        .in_Ready   (in_Ready),
        .out_Word   (out_Word),
        .out_Valid  (out_Valid),
        .out_Ready  (out_Ready),
        .mult_A11   (mult_A11),
        .mult_A12   (mult_A12),
        .mult_A21   (mult_A21),
        .mult_A22   (mult_A22),
        .mult_B11   (mult_B11),
        .mult_B12   (mult_B12),
        .mult_B21   (mult_B21),
        .mult_B22   (mult_B22),
        .mult_Start (mult_Start),
        .mult_Stable(mult_Stable),
        .mult_AB_Ack(mult_AB_Ack),
        .mult_Done  (mult_Done),
        .mult_C11   (mult_C11),
        .mult_C12   (mult_C12),
        .mult_C21   (mult_C21),
        .mult_C22   (mult_C22),
        .mult_C_Ack (mult_C_Ack),
        .busy       (busy),
        .err_Timeout(err_Timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL global_time_limit: simulation still running, required to finish");
        $fatal(1);
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic check256(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [255:0] ops_now;
    assign ops_now = {mult_B22, mult_B21, mult_B12, mult_B11,
                      mult_A22, mult_A21, mult_A12, mult_A11};

    // ---------------- multiplier model ----------------
    int          m_ack_delay = 1;
    int          m_latency   = 10;
    int          m_done_hold = 0;
    logic [31:0] m_plan [4];
    logic [31:0] exp_q [$];
    int          cack_pulses = 0;

    always @(posedge mult_C_Ack) cack_pulses = cack_pulses + 1;

    initial begin : mult_model
        int           phase;
        int           cnt;
        logic [255:0] snap;
        phase = 0;
        cnt = 0;
        snap = '0;
        mult_AB_Ack = 1'b0;
        mult_Done = 1'b0;
        mult_C11 = '0;
        mult_C12 = '0;
        mult_C21 = '0;
        mult_C22 = '0;
        forever begin
            @(posedge clk);
            #2;
            if (!rst_n) begin
                phase = 0;
                mult_AB_Ack = 1'b0;
                mult_Done = 1'b0;
            end else begin
                case (phase)
                    0: if (mult_Start) begin
                        snap = ops_now;
                        cnt = 0;
                        phase = 1;
                    end
                    1: begin
                        check32("stable_before_ack", 32'(mult_Stable), 1);
                        check256("operands_constant", ops_now, snap);
                        if (cnt >= m_ack_delay) begin
                            mult_AB_Ack = 1'b1;
                            phase = 2;
                        end else cnt++;
                    end
                    2: begin
                        check32("stable_during_ack", 32'(mult_Stable), 1);
                        if (!mult_Start) begin
                            mult_AB_Ack = 1'b0;
                            cnt = 0;
                            phase = 3;
                        end
                    end
                    3: begin
                        check32("stable_until_capture", 32'(mult_Stable), 1);
                        check256("operands_constant_wait", ops_now, snap);
                        if (cnt >= m_latency) begin
                            mult_C11 = m_plan[0];
                            mult_C12 = m_plan[1];
                            mult_C21 = m_plan[2];
                            mult_C22 = m_plan[3];
                            for (int k = 0; k < 4; k++) exp_q.push_back(m_plan[k]);
                            mult_Done = 1'b1;
                            phase = 4;
                        end else cnt++;
                    end
                    4: if (mult_C_Ack) begin
                        check32("stable_dropped_at_cack", 32'(mult_Stable), 0);
                        cnt = 0;
                        phase = 5;
                    end
                    5: begin
                        check32("cack_held_while_done", 32'(mult_C_Ack), 1);
                        if (cnt >= m_done_hold) begin
                            mult_Done = 1'b0;
                            phase = 6;
                        end else cnt++;
                    end
                    default: if (!mult_C_Ack) phase = 0;
                endcase
            end
        end
    end

    // ---------------- transaction helpers ----------------
    task automatic load_ops(input logic [31:0] ops[8], input int gap);
        int   i = 0;
        int   cyc = 0;
        int   early = 0;
        logic rdy;
        while (i < 8 && cyc < 300) begin
            case (gap)
                0:       in_Valid = 1'b1;
                1:       in_Valid = ((cyc % 2) == 0);
                default: in_Valid = 1'($urandom_range(0, 1));
            endcase
            in_Word = in_Valid ? ops[i] : $urandom();
            rdy = in_Ready;
            step();
            cyc++;
            if (in_Valid && rdy) begin
                i++;
                if (i < 8 && mult_Start) early = 1;
            end
        end
        in_Valid = 1'b0;
        in_Word = $urandom();
        check32("load_accept_count", 32'(i), 8);
        check32("start_before_8th", 32'(early), 0);
    endtask

    task automatic check_start(input logic [31:0] ops[8]);
        int          n = 0;
        logic [31:0] seen [8];
        while (!mult_Start && n < 8) begin
            step();
            n++;
        end
        check32("start_seen", 32'(mult_Start), 1);
        check32("busy_running", 32'(busy), 1);
        check32("in_ready_running", 32'(in_Ready), 0);
        seen = '{mult_A11, mult_A12, mult_A21, mult_A22,
                 mult_B11, mult_B12, mult_B21, mult_B22};
        for (int k = 0; k < 8; k++) check32($sformatf("operand_%0d", k), seen[k], ops[k]);
    endtask

    task automatic drain(input int stall, output logic [31:0] got[4], output int ngot);
        int          cyc = 0;
        int          stall_left = stall;
        int          stalling = 0;
        int          rdy_bad = 0;
        int          hold_bad = 0;
        int          extra = 0;
        logic        v;
        logic [31:0] w;
        logic [31:0] held = '0;
        ngot = 0;
        for (int k = 0; k < 4; k++) got[k] = 'x;
        out_Ready = 1'b0;
        while (ngot < 4 && cyc < 500) begin
            if (in_Ready) rdy_bad = 1;
            if (out_Valid) begin
                if (stalling != 0 && out_Word !== held) hold_bad = 1;
                if (stall_left > 0) begin
                    held = out_Word;
                    stalling = 1;
                    out_Ready = 1'b0;
                    stall_left--;
                end else begin
                    out_Ready = 1'b1;
                end
            end else begin
                out_Ready = 1'b0;
            end
            v = out_Valid;
            w = out_Word;
            step();
            cyc++;
            if (v && out_Ready) begin
                got[ngot] = w;
                ngot++;
                stall_left = stall;
                stalling = 0;
            end
        end
        out_Ready = 1'b0;
        check32("out_count", 32'(ngot), 4);
        check32("in_ready_low_until_4th", 32'(rdy_bad), 0);
        check32("out_word_stable_stalled", 32'(hold_bad), 0);
        check32("in_ready_after_drain", 32'(in_Ready), 1);
        check32("busy_after_drain", 32'(busy), 0);
        out_Ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            if (out_Valid) extra = 1;
        end
        out_Ready = 1'b0;
        check32("no_fifth_output", 32'(extra), 0);
    endtask

    typedef struct {
        string       name;
        logic [31:0] ops [8];
        logic [31:0] prod [4];
        int          gap;
        int          stall;
        int          ack_d;
        int          lat;
        int          hold;
    } vec_t;

    vec_t        vecs [4];
    logic [31:0] got [4];
    int          ngot;
    logic [31:0] ops_r [8];
    int          n;

    initial begin
        // A=[1,2;3,4] x I
        vecs[0].name = "basic";
        vecs[0].ops  = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                         32'h3F800000, 32'h00000000, 32'h00000000, 32'h3F800000};
        vecs[0].prod = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
        vecs[0].gap = 0; vecs[0].stall = 0; vecs[0].ack_d = 1; vecs[0].lat = 10; vecs[0].hold = 0;
        // A=[2,0;0,2] x B=[1,2;3,4] = [2,4;6,8]
        vecs[1].name = "backpressure";
        vecs[1].ops  = '{32'h40000000, 32'h00000000, 32'h00000000, 32'h40000000,
                         32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
        vecs[1].prod = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000};
        vecs[1].gap = 0; vecs[1].stall = 5; vecs[1].ack_d = 1; vecs[1].lat = 3; vecs[1].hold = 0;
        // A=[1,2;3,4] x B=[2,0;0,2] = [2,4;6,8]
        vecs[2].name = "gapped";
        vecs[2].ops  = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                         32'h40000000, 32'h00000000, 32'h00000000, 32'h40000000};
        vecs[2].prod = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000};
        vecs[2].gap = 1; vecs[2].stall = 0; vecs[2].ack_d = 0; vecs[2].lat = 2; vecs[2].hold = 0;
        // A=[1,1;1,1] x B=[1,2;3,4] = [4,6;4,6]
        vecs[3].name = "handshake";
        vecs[3].ops  = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
                         32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
        vecs[3].prod = '{32'h40800000, 32'h40C00000, 32'h40800000, 32'h40C00000};
        vecs[3].gap = 0; vecs[3].stall = 1; vecs[3].ack_d = 7; vecs[3].lat = 4; vecs[3].hold = 3;

        rst_n = 1'b0;
        in_Valid = 1'b0;
        in_Word = '0;
        out_Ready = 1'b0;
        step();
        step();
        check32("reset_in_ready", 32'(in_Ready), 0);
        check32("reset_flags", {25'b0, out_Valid, mult_Start, mult_Stable,
                                mult_C_Ack, busy, err_Timeout, 1'b0}, 0);
        check32("reset_out_word", out_Word, 0);
        check256("reset_operands", ops_now, '0);
        rst_n = 1'b1;
        step();
        check32("load_in_ready", 32'(in_Ready), 1);
        check32("load_busy", 32'(busy), 0);

        // Directed table
        for (int v = 0; v < 4; v++) begin
            m_ack_delay = vecs[v].ack_d;
            m_latency = vecs[v].lat;
            m_done_hold = vecs[v].hold;
            m_plan = vecs[v].prod;
            cack_pulses = 0;
            load_ops(vecs[v].ops, vecs[v].gap);
            check_start(vecs[v].ops);
            drain(vecs[v].stall, got, ngot);
            for (int k = 0; k < 4; k++)
                check32($sformatf("%s_word%0d", vecs[v].name, k), got[k], vecs[v].prod[k]);
            check32($sformatf("%s_cack_pulses", vecs[v].name), 32'(cack_pulses), 1);
        end

        // Reset while waiting for the result
        m_ack_delay = 1;
        m_latency = 30;
        m_done_hold = 0;
        load_ops(vecs[1].ops, 0);
        n = 0;
        while (!(mult_Stable && !mult_Start) && n < 50) begin
            step();
            n++;
        end
        check32("reached_wait_result", 32'(mult_Stable && !mult_Start), 1);
        rst_n = 1'b0;
        #1;
        check32("midreset_flags", {24'b0, in_Ready, out_Valid, mult_Start, mult_Stable,
                                   mult_C_Ack, busy, err_Timeout, 1'b0}, 0);
        check32("midreset_out_word", out_Word, 0);
        check256("midreset_operands", ops_now, '0);
        step();
        step();
        rst_n = 1'b1;
        step();
        check32("midreset_back_to_load", 32'(in_Ready), 1);
        m_latency = 5;
        m_plan = vecs[0].prod;
        cack_pulses = 0;
        load_ops(vecs[0].ops, 0);
        check_start(vecs[0].ops);
        drain(0, got, ngot);
        for (int k = 0; k < 4; k++)
            check32($sformatf("after_reset_word%0d", k), got[k], vecs[0].prod[k]);
        check32("after_reset_cack_pulses", 32'(cack_pulses), 1);

`ifdef AXA_TIMEOUT_EN
        begin
            int early;
            early = 0;
            m_ack_delay = 1;
            m_latency = 1000000;
            load_ops(vecs[2].ops, 0);
            n = 0;
            while (!mult_Start && n < 8) begin
                step();
                n++;
            end
            check32("timeout_start_seen", 32'(mult_Start), 1);
            for (int c = 1; c < 16; c++) begin
                step();
                if (err_Timeout) early = 1;
            end
            check32("timeout_not_early", 32'(early), 0);
            step();
            check32("timeout_err", 32'(err_Timeout), 1);
            check32("timeout_stable", 32'(mult_Stable), 0);
            check32("timeout_out_valid", 32'(out_Valid), 0);
            check32("timeout_in_ready", 32'(in_Ready), 1);
            rst_n = 1'b0;
            step();
            rst_n = 1'b1;
            step();
        end
`endif

        // Randomized transactions against the scoreboard
        for (int t = 0; t < 12; t++) begin
            for (int k = 0; k < 8; k++) ops_r[k] = $urandom();
            for (int k = 0; k < 4; k++) m_plan[k] = $urandom();
            m_ack_delay = $urandom_range(0, 4);
            m_latency = $urandom_range(0, 6);
            m_done_hold = $urandom_range(0, 3);
            exp_q.delete();
            cack_pulses = 0;
            load_ops(ops_r, 2);
            check_start(ops_r);
            drain($urandom_range(0, 3), got, ngot);
            check32($sformatf("rnd%0d_scoreboard_size", t), 32'(exp_q.size()), 4);
            for (int k = 0; k < 4; k++)
                if (k < exp_q.size())
                    check32($sformatf("rnd%0d_word%0d", t, k), got[k], exp_q[k]);
            check32($sformatf("rnd%0d_cack_pulses", t), 32'(cack_pulses), 1);
        end

        check32("err_timeout_final", 32'(err_Timeout), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
